myproject_mul_pipe: RTL and testbench

Parametrised, pipelined multiplier for the fixed-point datapath. It multiplies two operands of independent width and signedness and narrows the full product to a programmable output slice. A valid bit travels alongside the data, so upstream layers can stream operands and downstream accumulators consume results without a fixed schedule. It succeeds the per-size fixed-latency multiplier instances and has a configurable stage count, a clock enable, and optional saturation.

---
 rtl/myproject_mul_pipe.sv | 158 +++++++++++++++
 tb/tb_myproject_mul_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/myproject_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : myproject_mul_pipe
// Description : Pipelined A x B multiplier with a valid bit, clock enable and
//               programmable output slice. Saturation is built when the
//               macro MUL_PIPE_SAT_EN is defined; otherwise the slice wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module myproject_mul_pipe #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 17,
  parameter int A_SIGNED  = 1,
  parameter int B_SIGNED  = 0,
  parameter int P_WIDTH   = 28,
  parameter int P_SHIFT   = 0,
  parameter int NUM_STAGE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               in_valid,
  input  logic [A_WIDTH-1:0] din0,
  input  logic [B_WIDTH-1:0] din1,
  output logic               out_valid,
  output logic [P_WIDTH-1:0] dout,
  output logic               sat_flag
);

  localparam int FW = A_WIDTH + B_WIDTH + 1;

  logic [A_WIDTH-1:0]   r_a;
  logic [B_WIDTH-1:0]   r_b;
  logic                 r_v1;
  logic                 w_a_fill;
  logic                 w_b_fill;
  logic signed [FW-1:0] w_a_ext;
  logic signed [FW-1:0] w_b_ext;
  logic signed [FW-1:0] w_fp;
  logic signed [FW-1:0] w_fp_last;
  logic                 w_v_last;
  logic [P_WIDTH-1:0]   w_slice;
  logic [P_WIDTH-1:0]   w_dout_nx;
  logic                 r_out_valid;
  logic [P_WIDTH-1:0]   r_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_v1 <= 1'b0;
    end else if (ce) begin
      r_a  <= din0;
      r_b  <= din1;
      r_v1 <= in_valid;
    end
  end

  // Both operands widened to FW bits; the true product always fits in FW.
  assign w_a_fill = (A_SIGNED != 0) & r_a[A_WIDTH-1];
  assign w_b_fill = (B_SIGNED != 0) & r_b[B_WIDTH-1];
  assign w_a_ext  = {{(B_WIDTH+1){w_a_fill}}, r_a};
  assign w_b_ext  = {{(A_WIDTH+1){w_b_fill}}, r_b};
  assign w_fp     = w_a_ext * w_b_ext;

  generate
    if (NUM_STAGE == 2) begin : g_direct
      assign w_fp_last = w_fp;
      assign w_v_last  = r_v1;
    end else begin : g_delay
      localparam int ND = NUM_STAGE - 2;
      logic signed [FW-1:0] r_pd [ND];
      logic                 r_vd [ND];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < ND; i++) begin
            r_pd[i] <= '0;
            r_vd[i] <= 1'b0;
          end
        end else if (ce) begin
          r_pd[0] <= w_fp;
          r_vd[0] <= r_v1;
          for (int i = 1; i < ND; i++) begin
            r_pd[i] <= r_pd[i-1];
            r_vd[i] <= r_vd[i-1];
          end
        end
      end

      assign w_fp_last = r_pd[ND-1];
      assign w_v_last  = r_vd[ND-1];
    end
  endgenerate

  // Q = FP >>> P_SHIFT; its low P_WIDTH bits are a plain slice of FP.
  assign w_slice = w_fp_last[P_SHIFT +: P_WIDTH];

`ifdef MUL_PIPE_SAT_EN
  localparam int TOP = P_SHIFT + P_WIDTH;
  localparam logic [P_WIDTH-1:0] C_SMAX = {P_WIDTH{1'b1}} >> 1;
  localparam logic [P_WIDTH-1:0] C_SMIN = ~C_SMAX;

  logic w_in_range;
  logic w_sat_nx;
  logic r_sat;

  generate
    if (A_SIGNED == 0 && B_SIGNED == 0) begin : g_sat_unsigned
      assign w_in_range = ~|w_fp_last[FW-1:TOP];
    end else begin : g_sat_signed
      assign w_in_range = (&w_fp_last[FW-1:TOP-1]) | (~|w_fp_last[FW-1:TOP-1]);
    end
  endgenerate

  always_comb begin
    w_dout_nx = w_slice;
    w_sat_nx  = 1'b0;
    if (!w_in_range) begin
      w_sat_nx = 1'b1;
      if (A_SIGNED == 0 && B_SIGNED == 0) begin
        w_dout_nx = {P_WIDTH{1'b1}};
      end else if (w_fp_last[FW-1]) begin
        w_dout_nx = C_SMIN;
      end else begin
        w_dout_nx = C_SMAX;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (ce) begin
      r_sat <= w_sat_nx;
    end
  end

  assign sat_flag = r_sat;
`else
  assign w_dout_nx = w_slice;
  assign sat_flag  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_dout      <= '0;
    end else if (ce) begin
      r_out_valid <= w_v_last;
      r_dout      <= w_dout_nx;
    end
  end

  assign out_valid = r_out_valid;
  assign dout      = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_myproject_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_myproject_mul_pipe
// Description : Self-checking bench for myproject_mul_pipe (default build and
//               MUL_PIPE_SAT_EN build) with a queue-based latency model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_myproject_mul_pipe;

  localparam int AW = 18;
  localparam int BW = 17;
  localparam int PW = 28;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ce;
  logic          in_valid;
  logic [AW-1:0] din0;
  logic [BW-1:0] din1;
  logic          out_valid;
  logic [PW-1:0] dout;
  logic          sat_flag;

  logic          u_valid_in;
  logic [AW-1:0] u_a;
  logic [BW-1:0] u_b;
  logic          u_ov;
  logic [PW-1:0] u_dout;
  logic          u_sat;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  myproject_mul_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .in_valid  (in_valid),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .dout      (dout),
    .sat_flag  (sat_flag)
  );

  myproject_mul_pipe #(.A_SIGNED(0), .P_SHIFT(4)) dut_u (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (1'b1),
    .in_valid  (u_valid_in),
    .din0      (u_a),
    .din1      (u_b),
    .out_valid (u_ov),
    .dout      (u_dout),
    .sat_flag  (u_sat)
  );

  function automatic longint sx(input longint unsigned v, input int w, input int sg);
    if (sg != 0 && v[w-1]) return longint'(v) - (longint'(1) << w);
    return longint'(v);
  endfunction

  // Reference: exact product, arithmetic shift, then wrap or clamp.
  function automatic void ref_out(input longint unsigned a, input longint unsigned b,
                                  input int asg, input int bsg, input int sh,
                                  output logic [PW-1:0] d, output bit s);
    longint p, q, lo, hi;
    p = sx(a, AW, asg) * sx(b, BW, bsg);
    q = p >>> sh;
    d = PW'(q);
    s = 1'b0;
    lo = 0;
    hi = 0;
`ifdef MUL_PIPE_SAT_EN
    if (asg == 0 && bsg == 0) begin
      lo = 0;
      hi = (longint'(1) << PW) - 1;
    end else begin
      lo = -(longint'(1) << (PW-1));
      hi = (longint'(1) << (PW-1)) - 1;
    end
    if (q > hi) begin
      d = PW'(hi);
      s = 1'b1;
    end else if (q < lo) begin
      d = PW'(lo);
      s = 1'b1;
    end
`endif
  endfunction

  typedef struct {
    int            left;
    logic [PW-1:0] d;
    bit            s;
  } ent_t;

  ent_t          pq[$];
  logic          m_valid;
  logic [PW-1:0] m_dout;
  bit            m_sat;

  // Each accepted pair waits NS enabled edges (counting its own).
  always @(posedge clk or negedge rst_n) begin : model
    ent_t e;
    if (!rst_n) begin
      pq.delete();
      m_valid = 1'b0;
      m_dout  = '0;
      m_sat   = 1'b0;
    end else if (ce) begin
      for (int i = 0; i < pq.size(); i++) pq[i].left--;
      if (pq.size() != 0 && pq[0].left == 0) begin
        e       = pq.pop_front();
        m_valid = 1'b1;
        m_dout  = e.d;
        m_sat   = e.s;
      end else begin
        m_valid = 1'b0;
      end
      if (in_valid) begin
        ref_out(din0, din1, 1, 0, 0, e.d, e.s);
        e.left = NS - 1;
        pq.push_back(e);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut();
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      chk("dout", 64'(dout), 64'(m_dout));
      chk("sat_flag", 64'(sat_flag), 64'(m_sat));
    end
  endtask

  task automatic step(input bit c, input bit v, input logic [AW-1:0] a, input logic [BW-1:0] b);
    @(negedge clk);
    check_dut();
    ce       = c;
    in_valid = v;
    din0     = a;
    din1     = b;
  endtask

  initial begin
    logic [PW-1:0] ed;
    bit            es;
    logic [AW-1:0] ua;
    logic [BW-1:0] ub;

    rst_n = 1'b0; ce = 1'b1; in_valid = 1'b0; din0 = '0; din1 = '0;
    u_valid_in = 1'b0; u_a = '0; u_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_sat", 64'(sat_flag), 64'd0);
    chk("rst_u_valid", 64'(u_ov), 64'd0);
    rst_n = 1'b1;

    // basic signed x unsigned
    step(1, 1, 18'h3FFFD, 17'd5);
    repeat (3) step(1, 0, '0, '0);
    @(negedge clk);
    chk("basic_valid", 64'(out_valid), 64'd1);
    chk("basic_dout", 64'(dout), 64'hFFFFFF1);
    repeat (2) step(1, 0, '0, '0);

    // clock-enable stall of three cycles
    step(1, 1, 18'h3FFFD, 17'd5);
    step(1, 0, '0, '0);
    repeat (3) step(0, 0, '0, '0);
    repeat (5) step(1, 0, '0, '0);

    // overflow
    step(1, 1, 18'h20000, 17'h1FFFF);
    repeat (3) step(1, 0, '0, '0);
    @(negedge clk);
    chk("ovf_valid", 64'(out_valid), 64'd1);
`ifdef MUL_PIPE_SAT_EN
    chk("ovf_dout", 64'(dout), 64'h8000000);
    chk("ovf_sat", 64'(sat_flag), 64'd1);
`else
    chk("ovf_dout", 64'(dout), 64'h0020000);
    chk("ovf_sat", 64'(sat_flag), 64'd0);
`endif

    // streaming back-to-back
    for (int i = 0; i < 8; i++) step(1, 1, AW'(i), BW'(i + 1));
    repeat (6) step(1, 0, '0, '0);

    // random traffic with random ce gaps
    for (int i = 0; i < 300; i++)
      step(($urandom % 5) != 0, $urandom % 2, AW'($urandom), BW'($urandom));
    repeat (8) step(1, 0, '0, '0);

    // reset with results in flight
    for (int i = 0; i < 4; i++) step(1, 1, AW'($urandom), BW'($urandom));
    @(negedge clk);
    check_dut();
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rstmid_valid", 64'(out_valid), 64'd0);
    chk("rstmid_dout", 64'(dout), 64'd0);
    chk("rstmid_sat", 64'(sat_flag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) step(1, 0, '0, '0);

    // unsigned A with P_SHIFT=4 on the second instance
    for (int k = 0; k < 6; k++) begin
      ua = (k == 0) ? 18'h3FFFF : AW'($urandom);
      ub = (k == 0) ? 17'd2 : BW'($urandom);
      @(negedge clk);
      u_a = ua; u_b = ub; u_valid_in = 1'b1;
      @(negedge clk);
      u_valid_in = 1'b0;
      repeat (3) @(negedge clk);
      ref_out(ua, ub, 0, 0, 4, ed, es);
      chk("u_valid", 64'(u_ov), 64'd1);
      chk("u_dout", 64'(u_dout), 64'(ed));
      chk("u_sat", 64'(u_sat), 64'(es));
      if (k == 0) chk("u_const", 64'(u_dout), 64'h7FFF);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
